// File: rtl/data_mem_ctl.sv
// data_mem_ctl: word memory that is zeroed by a clear sweep, with 1- or 2-cycle pipelined reads,
// range checking and phase-gated writes. Define DATA_MEM_BYPASS_EN for same-address write forwarding.
module data_mem_ctl #(
  parameter int N        = 256,
  parameter int W        = 8,
  parameter int RD_LAT   = 1,
  parameter int WR_PHASE = 2,
  localparam int AW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          Init,
  input  logic [1:0]    Counter,
  input  logic [AW-1:0] DataAddr,
  input  logic          ReadMem,
  input  logic          WriteMem,
  input  logic [W-1:0]  DataIn,
  output logic [W-1:0]  DataOut,
  output logic          RdValid,
  output logic          Busy
);

  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

  state_t        state_r, state_s;
  logic [AW-1:0] ptr_r, ptr_s;
  logic [W-1:0]  core_r [N];
  logic          in_range_s, acc_s, wr_s, rd_s;
  logic [W-1:0]  rdata_s;

  generate
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
      $error("data_mem_ctl: RD_LAT must be 1 or 2");
    end
  endgenerate

  // Sweep sequencing; Init in either state (re)starts the sweep at word 0.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    case (state_r)
      CLEAR: begin
        if (Init) begin
          ptr_s = {AW{1'b0}};
        end else if (ptr_r == AW'(N - 1)) begin
          state_s = IDLE;
          ptr_s   = {AW{1'b0}};
        end else begin
          ptr_s = ptr_r + AW'(1);
        end
      end
      IDLE: begin
        if (Init) begin
          state_s = CLEAR;
          ptr_s   = {AW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = CLEAR;
        ptr_s   = {AW{1'b0}};
      end
    endcase
  end

  // Access qualification and read-data selection.
  always_comb begin
    in_range_s = ({1'b0, DataAddr} < (AW + 1)'(N));
    acc_s      = (state_r == IDLE) && !Init;
    wr_s       = acc_s && WriteMem && (Counter == 2'(WR_PHASE)) && in_range_s;
    rd_s       = acc_s && ReadMem;
    rdata_s    = {W{1'b0}};
`ifdef DATA_MEM_BYPASS_EN
    if (wr_s) begin
      rdata_s = DataIn;
    end else if (in_range_s) begin
      rdata_s = core_r[DataAddr];
    end else begin
      rdata_s = {W{1'b0}};
    end
`else
    if (in_range_s) begin
      rdata_s = core_r[DataAddr];
    end else begin
      rdata_s = {W{1'b0}};
    end
`endif
  end

  // Control state; Busy is registered from the next state so it tracks CLEAR exactly.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_r <= CLEAR;
      ptr_r   <= {AW{1'b0}};
      Busy    <= 1'b1;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      Busy    <= (state_s == CLEAR);
    end
  end

  // Core array has no reset; the sweep is what zeroes it.
  always_ff @(posedge CLK) begin
    if (state_r == CLEAR) begin
      core_r[ptr_r] <= {W{1'b0}};
    end else if (wr_s) begin
      core_r[DataAddr] <= DataIn;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic         v1_r;
      logic [W-1:0] d1_r;

      // Two-stage read pipeline; DataOut holds between results.
      always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
          v1_r    <= 1'b0;
          d1_r    <= {W{1'b0}};
          RdValid <= 1'b0;
          DataOut <= {W{1'b0}};
        end else begin
          v1_r    <= rd_s;
          RdValid <= v1_r;
          if (rd_s) begin
            d1_r <= rdata_s;
          end
          if (v1_r) begin
            DataOut <= d1_r;
          end
        end
      end
    end else begin : g_lat1
      // Single-stage read; DataOut holds between results.
      always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
          RdValid <= 1'b0;
          DataOut <= {W{1'b0}};
        end else begin
          RdValid <= rd_s;
          if (rd_s) begin
            DataOut <= rdata_s;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_data_mem_ctl.sv
// Bench for data_mem_ctl: two instances (N=256/RD_LAT=1 and N=200/RD_LAT=2) share stimulus and are
// compared every cycle against a schedule-based memory model, plus directed literal checks.
module tb_data_mem_ctl;

  logic       CLK = 1'b0;
  logic       Reset, Init, ReadMem, WriteMem;
  logic [1:0] Counter;
  logic [7:0] DataAddr, DataIn;
  logic [7:0] DataOut0, DataOut1;
  logic       RdValid0, RdValid1, Busy0, Busy1;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  data_mem_ctl #(.N(256), .W(8), .RD_LAT(1), .WR_PHASE(2)) dut0 (
    .CLK(CLK), .Reset(Reset), .Init(Init), .Counter(Counter), .DataAddr(DataAddr),
    .ReadMem(ReadMem), .WriteMem(WriteMem), .DataIn(DataIn),
    .DataOut(DataOut0), .RdValid(RdValid0), .Busy(Busy0)
  );

  data_mem_ctl #(.N(200), .W(8), .RD_LAT(2), .WR_PHASE(2)) dut1 (
    .CLK(CLK), .Reset(Reset), .Init(Init), .Counter(Counter), .DataAddr(DataAddr),
    .ReadMem(ReadMem), .WriteMem(WriteMem), .DataIn(DataIn),
    .DataOut(DataOut1), .RdValid(RdValid1), .Busy(Busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int n_of(input int i);
    return (i == 0) ? 256 : 200;
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  // Model: rem = sweep cycles still to go; read results are scheduled by due cycle (slot = due mod 4).
  int         cyc;
  int         rem [2];
  bit         sv  [2][4];
  logic [7:0] sd  [2][4];
  logic [7:0] mem [2][256];
  bit         ev  [2];
  logic [7:0] eo  [2];

  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cyc <= 0;
      for (int i = 0; i < 2; i++) begin
        rem[i] <= n_of(i);
        ev[i]  <= 1'b0;
        eo[i]  <= 8'h00;
        for (int s = 0; s < 4; s++) sv[i][s] <= 1'b0;
        for (int a = 0; a < 256; a++) mem[i][a] <= 8'h00;
      end
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
        int         c, slot;
        bit         acc, inr, commit, push, nv;
        logic [7:0] v, nd;
        c      = cyc + 1;
        acc    = (rem[i] == 0) && !Init;
        inr    = int'(DataAddr) < n_of(i);
        commit = acc && WriteMem && (Counter == 2'd2) && inr;
        push   = acc && ReadMem;
        v      = inr ? mem[i][DataAddr] : 8'h00;
`ifdef DATA_MEM_BYPASS_EN
        if (commit) v = DataIn;
`endif
        slot = (c + lat_of(i) - 1) % 4;
        nv   = sv[i][c % 4];
        nd   = sd[i][c % 4];
        sv[i][c % 4] <= 1'b0;
        if (push && slot == c % 4) begin
          nv = 1'b1;
          nd = v;
        end else if (push) begin
          sv[i][slot] <= 1'b1;
          sd[i][slot] <= v;
        end
        ev[i] <= nv;
        if (nv) eo[i] <= nd;
        if (Init) begin
          rem[i] <= n_of(i);
          for (int a = 0; a < 256; a++) mem[i][a] <= 8'h00;
        end else if (rem[i] > 0) begin
          rem[i] <= rem[i] - 1;
        end
        if (commit) mem[i][DataAddr] <= DataIn;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    if (!Reset) begin
      check("model_busy0", Busy0, rem[0] != 0);
      check("model_busy1", Busy1, rem[1] != 0);
      check("model_rdvalid0", RdValid0, ev[0]);
      check("model_rdvalid1", RdValid1, ev[1]);
      check("model_dataout0", DataOut0, eo[0]);
      check("model_dataout1", DataOut1, eo[1]);
    end
  end

  task automatic drive(input bit ini, input bit [1:0] cnt, input bit [7:0] a,
                       input bit rd, input bit wr, input bit [7:0] d);
    Init = ini; Counter = cnt; DataAddr = a; ReadMem = rd; WriteMem = wr; DataIn = d;
    @(negedge CLK);
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while ((Busy0 || Busy1) && k < 400) begin
      idle();
      k++;
    end
    check("sweep_timeout", Busy0 || Busy1, 0);
  endtask

  initial begin
    int         b0, b1;
    logic [7:0] a, rbw;
    Reset = 1'b1;
    Init = 1'b0; Counter = 2'd0; DataAddr = 8'h00; ReadMem = 1'b0; WriteMem = 1'b0; DataIn = 8'h00;
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    check("rst_dataout0", DataOut0, 8'h00);
    check("rst_rdvalid1", RdValid1, 0);
    check("rst_busy0", Busy0, 1);

    b0 = 0; b1 = 0;
    for (int k = 0; k < 300; k++) begin
      if (Busy0) b0++;
      if (Busy1) b1++;
      idle();
    end
    check("busy_len0", b0, 256);
    check("busy_len1", b1, 200);

    drive(1'b0, 2'd0, 8'h33, 1'b1, 1'b0, 8'h00);
    check("clr_rv0", RdValid0, 1);
    check("clr_do0", DataOut0, 8'h00);
    idle();
    check("clr_rv1", RdValid1, 1);
    check("clr_do1", DataOut1, 8'h00);

    drive(1'b0, 2'd2, 8'h10, 1'b0, 1'b1, 8'hA5);
    drive(1'b0, 2'd0, 8'h10, 1'b1, 1'b0, 8'h00);
    check("a5_do0", DataOut0, 8'hA5);
    check("a5_rv0", RdValid0, 1);
    check("a5_rv1_early", RdValid1, 0);
    idle();
    check("a5_do1", DataOut1, 8'hA5);
    check("a5_rv1", RdValid1, 1);
    check("a5_rv0_pulse", RdValid0, 0);
    check("a5_hold0", DataOut0, 8'hA5);

    drive(1'b0, 2'd0, 8'h20, 1'b0, 1'b1, 8'h3C);
    drive(1'b0, 2'd1, 8'h20, 1'b0, 1'b1, 8'h3C);
    drive(1'b0, 2'd3, 8'h20, 1'b0, 1'b1, 8'h3C);
    drive(1'b0, 2'd0, 8'h20, 1'b1, 1'b0, 8'h00);
    check("phase_do0", DataOut0, 8'h00);
    idle();
    check("phase_do1", DataOut1, 8'h00);

    drive(1'b0, 2'd2, 8'd210, 1'b0, 1'b1, 8'h77);
    drive(1'b0, 2'd0, 8'h10, 1'b1, 1'b0, 8'h00);
    drive(1'b0, 2'd0, 8'd210, 1'b1, 1'b0, 8'h00);
    check("rng_do0", DataOut0, 8'h77);
    check("pipe_do1", DataOut1, 8'hA5);
    idle();
    check("rng_do1", DataOut1, 8'h00);
    check("rng_rv1", RdValid1, 1);
    drive(1'b0, 2'd0, 8'd199, 1'b1, 1'b0, 8'h00);
    idle();
    check("rng199_do1", DataOut1, 8'h00);

    drive(1'b0, 2'd2, 8'h05, 1'b0, 1'b1, 8'h11);
    drive(1'b0, 2'd2, 8'h05, 1'b1, 1'b1, 8'h5A);
`ifdef DATA_MEM_BYPASS_EN
    rbw = 8'h5A;
`else
    rbw = 8'h11;
`endif
    check("rbw_do0", DataOut0, rbw);
    idle();
    check("rbw_do1", DataOut1, rbw);
    drive(1'b0, 2'd0, 8'h05, 1'b1, 1'b0, 8'h00);
    idle();
    check("rbw_next1", DataOut1, 8'h5A);

    drive(1'b0, 2'd2, 8'h00, 1'b0, 1'b1, 8'hFF);
    drive(1'b1, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 2'd2, 8'h00, 1'b1, 1'b1, 8'hEE);
      check("sweep_rv0", RdValid0, 0);
      check("sweep_rv1", RdValid1, 0);
    end
    wait_ready();
    drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00);
    check("init_do0", DataOut0, 8'h00);
    check("init_rv0", RdValid0, 1);
    idle();
    check("init_do1", DataOut1, 8'h00);

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 1999) == 0) begin
        Reset = 1'b1;
        idle();
        Reset = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(0, 7));
      else if ($urandom_range(0, 2) == 0) a = 8'($urandom_range(195, 215));
      else a = 8'($urandom);
      drive($urandom_range(0, 599) == 0, 2'($urandom), a, 1'($urandom), 1'($urandom), 8'($urandom));
    end
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
